// File: rtl/alu_frame_controller.sv
// ============================================================================
// Module   : alu_frame_controller
// Brief    : Byte-stream command framer that drives the registered 16-bit ALU
//            and returns its result on a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_frame_controller #(
  parameter logic [3:0] SYNC_NIBBLE = 4'hA,
  parameter int         ALU_LAT     = 1,
  parameter int         ERR_CNT_W   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [15:0]          ALU_A,
  output logic [15:0]          ALU_B,
  output logic [3:0]           ALU_FUN_O,
  input  logic [15:0]          ALU_OUT_I,
  input  logic [3:0]           ALU_FLAGS_I,
  output logic [15:0]          res_data,
  output logic [3:0]           res_flags,
  output logic                 res_err,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] frame_err_cnt
);

  localparam int              c_CNT_W   = 3;
  localparam logic [c_CNT_W-1:0] c_LAT_CNT = c_CNT_W'(ALU_LAT);
  localparam logic [3:0]      c_FUN_DIV = 4'b0011;
  localparam logic [3:0]      c_FUN_NOP = 4'b1111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GET_A0 = 3'd1,
    GET_A1 = 3'd2,
    GET_B0 = 3'd3,
    GET_B1 = 3'd4,
    EXEC   = 3'd5,
    CAPT   = 3'd6,
    RESP   = 3'd7
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [15:0]            r_a;
  logic [15:0]            r_b;
  logic [3:0]             r_fun;
  logic [c_CNT_W-1:0]     r_wait;
  logic [15:0]            r_res_data;
  logic [3:0]             r_res_flags;
  logic                   r_res_err;
  logic                   r_res_valid;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic                   w_xfer;
  logic                   w_sync_ok;
  logic                   w_div0;
  logic                   w_in_ready;

  assign w_xfer    = in_valid && w_in_ready;
  assign w_sync_ok = (in_data[7:4] == SYNC_NIBBLE);
  // B is only complete at the B_hi accept edge, so test the incoming byte directly
  assign w_div0    = (r_fun == c_FUN_DIV) && ({in_data, r_b[7:0]} == 16'h0000);

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (w_xfer && w_sync_ok) w_next = GET_A0;
      end
      GET_A0: begin
        w_in_ready = 1'b1;
        if (w_xfer) w_next = GET_A1;
      end
      GET_A1: begin
        w_in_ready = 1'b1;
        if (w_xfer) w_next = GET_B0;
      end
      GET_B0: begin
        w_in_ready = 1'b1;
        if (w_xfer) w_next = GET_B1;
      end
      GET_B1: begin
        w_in_ready = 1'b1;
        if (w_xfer) w_next = w_div0 ? RESP : EXEC;
      end
      // Counting 0..ALU_LAT places the CAPT sample ALU_LAT+2 edges after B_hi
      EXEC:    if (r_wait == c_LAT_CNT) w_next = CAPT;
      CAPT:    w_next = RESP;
      RESP:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_a         <= '0;
      r_b         <= '0;
      r_fun       <= '0;
      r_wait      <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            if (w_sync_ok)       r_fun     <= in_data[3:0];
            else if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
          end
        end
        GET_A0: if (w_xfer) r_a[7:0]  <= in_data;
        GET_A1: if (w_xfer) r_a[15:8] <= in_data;
        GET_B0: if (w_xfer) r_b[7:0]  <= in_data;
        GET_B1: begin
          if (w_xfer) begin
            r_b[15:8] <= in_data;
            r_wait    <= '0;
            if (w_div0) begin
              r_res_data  <= 16'hFFFF;
              r_res_flags <= 4'b1000;
              r_res_err   <= 1'b1;
              r_res_valid <= 1'b1;
            end
          end
        end
        EXEC: r_wait <= r_wait + 1'b1;
        CAPT: begin
          r_res_data  <= ALU_OUT_I;
          r_res_flags <= ALU_FLAGS_I;
          r_res_err   <= (r_fun == c_FUN_NOP);
          r_res_valid <= 1'b1;
        end
        RESP: if (res_ready) r_res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready      = w_in_ready;
  assign busy          = (r_state != IDLE);
  assign ALU_A         = r_a;
  assign ALU_B         = r_b;
  assign ALU_FUN_O     = r_fun;
  assign res_data      = r_res_data;
  assign res_flags     = r_res_flags;
  assign res_err       = r_res_err;
  assign res_valid     = r_res_valid;
  assign frame_err_cnt = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_frame_controller.sv
// ============================================================================
// Module   : tb_alu_frame_controller
// Brief    : Directed self-checking bench; two controllers (ALU_LAT 1 and 3)
//            each paired with a behavioural registered ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_frame_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // instance with ALU_LAT=1 (suffix _1) and ALU_LAT=3 (suffix _3)
  logic [7:0]  in_data_1 = '0,  in_data_3 = '0;
  logic        in_valid_1 = 0,  in_valid_3 = 0;
  logic        res_ready_1 = 0, res_ready_3 = 0;
  logic        in_ready_1, in_ready_3;
  logic [15:0] alu_a_1, alu_a_3, alu_b_1, alu_b_3;
  logic [3:0]  alu_fun_1, alu_fun_3;
  logic [15:0] alu_out_1, alu_out_3;
  logic [3:0]  alu_flg_1, alu_flg_3;
  logic [15:0] res_data_1, res_data_3;
  logic [3:0]  res_flags_1, res_flags_3;
  logic        res_err_1, res_err_3, res_valid_1, res_valid_3, busy_1, busy_3;
  logic [7:0]  err_cnt_1, err_cnt_3;
  logic [19:0] p1;
  logic [19:0] q3 [3];

  always #5 CLK = ~CLK;

  alu_frame_controller #(.SYNC_NIBBLE(4'hA), .ALU_LAT(1), .ERR_CNT_W(8)) u_dut_1 (
    .CLK(CLK), .RST(RST), .in_data(in_data_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .ALU_A(alu_a_1), .ALU_B(alu_b_1), .ALU_FUN_O(alu_fun_1), .ALU_OUT_I(alu_out_1),
    .ALU_FLAGS_I(alu_flg_1), .res_data(res_data_1), .res_flags(res_flags_1), .res_err(res_err_1),
    .res_valid(res_valid_1), .res_ready(res_ready_1), .busy(busy_1), .frame_err_cnt(err_cnt_1));

  alu_frame_controller #(.SYNC_NIBBLE(4'hA), .ALU_LAT(3), .ERR_CNT_W(8)) u_dut_3 (
    .CLK(CLK), .RST(RST), .in_data(in_data_3), .in_valid(in_valid_3), .in_ready(in_ready_3),
    .ALU_A(alu_a_3), .ALU_B(alu_b_3), .ALU_FUN_O(alu_fun_3), .ALU_OUT_I(alu_out_3),
    .ALU_FLAGS_I(alu_flg_3), .res_data(res_data_3), .res_flags(res_flags_3), .res_err(res_err_3),
    .res_valid(res_valid_3), .res_ready(res_ready_3), .busy(busy_3), .frame_err_cnt(err_cnt_3));

  // Behavioural 16-bit ALU: returns {Arith,Logic,CMP,Shift flags, result}
  function automatic logic [19:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] f);
    logic [15:0] r;
    logic [3:0]  fl;
    r = '0; fl = 4'b0000;
    case (f)
      4'd0:  begin r = a + b;            fl = 4'b1000; end
      4'd1:  begin r = a - b;            fl = 4'b1000; end
      4'd2:  begin r = a * b;            fl = 4'b1000; end
      4'd3:  begin r = (b != 0) ? a / b : 16'h0; fl = 4'b1000; end
      4'd4:  begin r = a & b;            fl = 4'b0100; end
      4'd5:  begin r = a | b;            fl = 4'b0100; end
      4'd6:  begin r = ~(a & b);         fl = 4'b0100; end
      4'd7:  begin r = ~(a | b);         fl = 4'b0100; end
      4'd8:  begin r = a ^ b;            fl = 4'b0100; end
      4'd9:  begin r = ~(a ^ b);         fl = 4'b0100; end
      4'd10: begin r = (a == b) ? 16'd1 : 16'd0; fl = 4'b0010; end
      4'd11: begin r = (a > b)  ? 16'd2 : 16'd0; fl = 4'b0010; end
      4'd12: begin r = (a < b)  ? 16'd3 : 16'd0; fl = 4'b0010; end
      4'd13: begin r = a >> 1;           fl = 4'b0001; end
      4'd14: begin r = a << 1;           fl = 4'b0001; end
      default: begin r = '0;             fl = 4'b0000; end
    endcase
    return {fl, r};
  endfunction

  always @(posedge CLK) begin
    p1    <= alu_f(alu_a_1, alu_b_1, alu_fun_1);
    q3[0] <= alu_f(alu_a_3, alu_b_3, alu_fun_3);
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign {alu_flg_1, alu_out_1} = p1;
  assign {alu_flg_3, alu_out_3} = q3[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? in_ready_1 : in_ready_3;
  endfunction

  function automatic logic vld(input int sel);
    return (sel == 0) ? res_valid_1 : res_valid_3;
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    int n = 0;
    if (sel == 0) begin in_data_1 = b; in_valid_1 = 1'b1; end
    else          begin in_data_3 = b; in_valid_3 = 1'b1; end
    while (!rdy(sel) && n < 50) begin tick(); n++; end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    tick();
    in_valid_1 = 1'b0;
    in_valid_3 = 1'b0;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] c, input logic [7:0] a0,
                            input logic [7:0] a1, input logic [7:0] b0, input logic [7:0] b1);
    send_byte(sel, c); send_byte(sel, a0); send_byte(sel, a1);
    send_byte(sel, b0); send_byte(sel, b1);
  endtask

  // Edges from the last accept edge until res_valid; -1 on timeout
  task automatic wait_resp(input int sel, output int lat);
    int n = 0;
    while (!vld(sel) && n < 20) begin tick(); n++; end
    lat = vld(sel) ? n : -1;
  endtask

  task automatic ack(input int sel);
    if (sel == 0) res_ready_1 = 1'b1; else res_ready_3 = 1'b1;
    tick();
    res_ready_1 = 1'b0;
    res_ready_3 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    RST = 1'b0;
    tick(); tick();
    check("rst_valid",   res_valid_1, 0);
    check("rst_busy",    busy_1, 0);
    check("rst_ready",   in_ready_1, 1);
    check("rst_data",    res_data_1, 0);
    check("rst_flags",   res_flags_1, 0);
    check("rst_errcnt",  err_cnt_1, 0);
    RST = 1'b1;
    tick();
    check("idle_ready",  in_ready_1, 1);

    // ADD with a 3-cycle gap mid-frame
    send_byte(0, 8'hA0); send_byte(0, 8'h34); send_byte(0, 8'h12);
    tick(); tick(); tick();
    check("gap_busy",    busy_1, 1);
    check("gap_ready",   in_ready_1, 1);
    send_byte(0, 8'h01); send_byte(0, 8'h00);
    check("add_a",       alu_a_1, 32'h1234);
    check("add_b",       alu_b_1, 32'h0001);
    wait_resp(0, lat);
    check("add_lat",     lat, 3);
    check("add_data",    res_data_1, 32'h1235);
    check("add_flags",   res_flags_1, 4'b1000);
    check("add_err",     res_err_1, 0);
    ack(0);
    check("add_done",    res_valid_1, 0);

    // compare A>B under backpressure, with a byte offered during RESP
    send_frame(0, 8'hAB, 8'h05, 8'h00, 8'h03, 8'h00);
    wait_resp(0, lat);
    check("cmp_lat",     lat, 3);
    in_data_1 = 8'h5D; in_valid_1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data",   res_data_1, 32'h0002);
      check("bp_flags",  res_flags_1, 4'b0010);
      check("bp_ready",  in_ready_1, 0);
      check("bp_valid",  res_valid_1, 1);
    end
    in_valid_1 = 1'b0;
    ack(0);
    check("bp_rel_valid", res_valid_1, 0);
    check("bp_rel_busy",  busy_1, 0);
    check("bp_rel_ready", in_ready_1, 1);
    check("bp_errcnt",    err_cnt_1, 0);

    // divide by zero short-circuits to RESP on the B_hi accept edge
    send_frame(0, 8'hA3, 8'h10, 8'h00, 8'h00, 8'h00);
    check("div0_valid",  res_valid_1, 1);
    check("div0_data",   res_data_1, 32'hFFFF);
    check("div0_flags",  res_flags_1, 4'b1000);
    check("div0_err",    res_err_1, 1);
    ack(0);

    // bad sync byte then a valid SHL frame
    send_byte(0, 8'h5D);
    check("bad_cnt1",    err_cnt_1, 1);
    check("bad_busy",    busy_1, 0);
    send_frame(0, 8'hAE, 8'h01, 8'h80, 8'h00, 8'h00);
    wait_resp(0, lat);
    check("shl_lat",     lat, 3);
    check("shl_data",    res_data_1, 32'h0002);
    check("shl_flags",   res_flags_1, 4'b0001);
    check("shl_err",     res_err_1, 0);
    ack(0);
    check("shl_cnt",     err_cnt_1, 1);
    for (int i = 0; i < 253; i++) send_byte(0, 8'h5D);
    check("sat_fe",      err_cnt_1, 8'hFE);
    for (int i = 0; i < 3; i++) send_byte(0, 8'h3C);
    check("sat_ff",      err_cnt_1, 8'hFF);

    // reset mid-frame discards everything
    send_byte(0, 8'hA0); send_byte(0, 8'hFF);
    RST = 1'b0;
    tick();
    check("mrst_a",      alu_a_1, 0);
    check("mrst_fun",    alu_fun_1, 0);
    check("mrst_busy",   busy_1, 0);
    check("mrst_ready",  in_ready_1, 1);
    check("mrst_cnt",    err_cnt_1, 0);
    check("mrst_data",   res_data_1, 0);
    RST = 1'b1;
    send_frame(0, 8'hA1, 8'h05, 8'h00, 8'h02, 8'h00);
    wait_resp(0, lat);
    check("sub_lat",     lat, 3);
    check("sub_data",    res_data_1, 32'h0003);
    ack(0);

    // FUN=1111 is flagged as an error response
    send_frame(0, 8'hAF, 8'h01, 8'h00, 8'h01, 8'h00);
    wait_resp(0, lat);
    check("nop_lat",     lat, 3);
    check("nop_data",    res_data_1, 0);
    check("nop_flags",   res_flags_1, 0);
    check("nop_err",     res_err_1, 1);
    ack(0);

    // ALU_LAT=3 instance
    send_frame(1, 8'hA0, 8'h34, 8'h12, 8'h01, 8'h00);
    wait_resp(1, lat);
    check("lat3_lat",    lat, 5);
    check("lat3_data",   res_data_3, 32'h1235);
    check("lat3_flags",  res_flags_3, 4'b1000);
    ack(1);
    check("lat3_done",   res_valid_3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
